// File: rtl/lcd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_pkg
//   Shared definitions for the HD44780 character-LCD sequencer:
//   - state_t        : sequencer states
//   - INIT_ROM       : controller init bytes (all RS = 0), INIT_LEN entries
//   - LCD_*_BIT      : bit positions inside the o_io_lcd word
//   - OPC_CLEAR/HOME : commands that need the long post-byte wait
//   - is_slow_cmd()  : selects the long wait for clear/home commands
// -----------------------------------------------------------------------------
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_WAIT  = 3'd5,
        S_IDLE  = 3'd6
    } state_t;

    localparam int INIT_LEN = 6;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    localparam logic [7:0] OPC_CLEAR = 8'h01;
    localparam logic [7:0] OPC_HOME  = 8'h02;

    // Clear and home are the only instructions the controller needs ~1.6 ms for.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == OPC_CLEAR) || (data == OPC_HOME));
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_if
//   Byte request handshake between the LSU (master) and lcd_ctrl (slave).
//   vld  : request valid             (master -> slave)
//   rs   : 0 = command, 1 = data     (master -> slave)
//   data : byte to write             (master -> slave)
//   rdy  : request accepted when vld && rdy on a clock edge (slave -> master)
// -----------------------------------------------------------------------------
interface lcd_ctrl_if;
    logic       vld;
    logic       rs;
    logic [7:0] data;
    logic       rdy;

    modport master (output vld, output rs, output data, input  rdy);
    modport slave  (input  vld, input  rs, input  data, output rdy);
endinterface

// File: rtl/lcd_req_fifo.sv
// -----------------------------------------------------------------------------
// lcd_req_fifo
//   Synchronous FIFO for {rs, data} requests, used only when LCD_FIFO_EN is
//   defined. DEPTH must be a power of two >= 2.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push/i_wdata : write request; accepted when not full, or when a pop
//                    happens in the same cycle (slot freed combinationally)
//   i_pop          : remove the head entry (ignored when empty)
//   o_rdata        : head entry (combinational)
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module lcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
//   HD44780 character-LCD sequencer. After reset it idles for the power-up
//   time, writes the init bytes, then issues command/data bytes from the LSU,
//   each as setup -> EN pulse -> hold -> busy wait.
//   Optional feature macro: LCD_FIFO_EN (request FIFO of P_FIFO_DEPTH entries;
//   default build uses a single holding register and accepts only when idle).
//   i_clk    : system clock
//   i_reset  : asynchronous active-low reset
//   io_req   : request handshake (lcd_ctrl_if.slave)
//   o_busy   : sequence running or requests pending
//   o_io_lcd : [31] ON, [10] EN, [9] RS, [8] RW (always 0), [7:0] DATA
// -----------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
`ifdef LCD_FIFO_EN
    parameter int P_FIFO_DEPTH   = 4,
`endif
    parameter int P_PWRUP_CYC    = 750000,
    parameter int P_SETUP_CYC    = 2,
    parameter int P_EN_CYC       = 12,
    parameter int P_HOLD_CYC     = 2,
    parameter int P_CMD_WAIT_CYC = 2000,
    parameter int P_CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    lcd_ctrl_if.slave   io_req,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);
    function automatic int len_of(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PWRUP_LEN = len_of(P_PWRUP_CYC);
    localparam int SETUP_LEN = len_of(P_SETUP_CYC);
    localparam int EN_LEN    = len_of(P_EN_CYC);
    localparam int HOLD_LEN  = len_of(P_HOLD_CYC);
    localparam int CMD_LEN   = len_of(P_CMD_WAIT_CYC);
    localparam int CLR_LEN   = len_of(P_CLR_WAIT_CYC);
    localparam int MAX_LEN   = max2(max2(max2(PWRUP_LEN, SETUP_LEN), max2(EN_LEN, HOLD_LEN)),
                                    max2(CMD_LEN, CLR_LEN));
    localparam int CNT_W     = $clog2(MAX_LEN) + 1;
    localparam int IDX_W     = $clog2(INIT_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_on;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             w_load;
    logic             w_init_done;
    logic             w_pending;
    logic             w_head_rs;
    logic [7:0]       w_head_data;
    logic [7:0]       w_init_byte;

    assign w_init_done = (r_idx == IDX_W'(INIT_LEN));

    always_comb begin
        w_init_byte = 8'h00;
        if (r_idx < IDX_W'(INIT_LEN)) begin
            w_init_byte = INIT_ROM[r_idx];
        end
    end

`ifdef LCD_FIFO_EN
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic [8:0] w_head;

    // Requests are popped only when the sequencer loads a non-init byte; that
    // pop also frees a slot for a push in the same cycle. r_on holds rdy low
    // while reset is asserted.
    assign w_pop      = w_load && w_init_done;
    assign io_req.rdy = r_on && (!w_full || w_pop);
    assign w_push     = io_req.vld && io_req.rdy;

    lcd_req_fifo #(
        .DEPTH (P_FIFO_DEPTH),
        .WIDTH (9)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({io_req.rs, io_req.data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pending   = !w_empty;
    assign w_head_rs   = w_head[8];
    assign w_head_data = w_head[7:0];
`else
    logic       r_pend;
    logic       r_hold_rs;
    logic [7:0] r_hold_data;
    logic       w_accept;

    // Only one request in flight: the CPU store stalls until the LCD is idle.
    assign io_req.rdy = (r_state == S_IDLE) && w_init_done && !r_pend;
    assign w_accept   = io_req.vld && io_req.rdy;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pend <= 1'b0;
        end else if (w_accept) begin
            r_pend <= 1'b1;
        end else if (w_load && w_init_done) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_hold_rs   <= io_req.rs;
            r_hold_data <= io_req.data;
        end
    end

    assign w_pending   = r_pend;
    assign w_head_rs   = r_hold_rs;
    assign w_head_data = r_hold_data;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - 1'b1) : '0;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            S_PWRUP: begin
                // The counter is 0 straight out of reset; that first cycle
                // counts as power-up cycle 1, so the remainder is loaded.
                if ((r_cnt == '0) && (PWRUP_LEN > 1)) begin
                    w_cnt_nxt = CNT_W'(PWRUP_LEN - 1);
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = CNT_W'(SETUP_LEN);
            end
            S_SETUP: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = CNT_W'(EN_LEN);
                end
            end
            S_PULSE: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CNT_W'(HOLD_LEN);
                end
            end
            S_HOLD: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = is_slow_cmd(r_rs, r_data) ? CNT_W'(CLR_LEN) : CNT_W'(CMD_LEN);
                end
            end
            S_WAIT: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = w_pending ? S_LOAD : S_IDLE;
                    if (!w_init_done) begin
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx != IDX_W'(INIT_LEN - 1)) begin
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (w_pending) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_on    <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_on    <= 1'b1;
            if (w_load) begin
                r_rs   <= w_init_done ? w_head_rs   : 1'b0;
                r_data <= w_init_done ? w_head_data : w_init_byte;
            end
        end
    end

    assign o_busy = (r_state != S_IDLE) || w_pending;

    // EN comes straight from the state register so a reset drops it at once.
    always_comb begin
        o_io_lcd             = 32'h0000_0000;
        o_io_lcd[LCD_ON_BIT] = r_on;
        o_io_lcd[LCD_EN_BIT] = (r_state == S_PULSE);
        o_io_lcd[LCD_RS_BIT] = r_rs;
        o_io_lcd[LCD_RW_BIT] = 1'b0;
        o_io_lcd[7:0]        = r_data;
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;
    localparam int PWRUP = 20;
    localparam int SETUP = 2;
    localparam int ENC   = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int CLRW  = 30;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] lcd;

    lcd_ctrl_if req_if();

    lcd_ctrl #(
        .P_PWRUP_CYC    (PWRUP),
        .P_SETUP_CYC    (SETUP),
        .P_EN_CYC       (ENC),
        .P_HOLD_CYC     (HOLD),
        .P_CMD_WAIT_CYC (CMDW),
        .P_CLR_WAIT_CYC (CLRW)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .io_req   (req_if),
        .o_busy   (busy),
        .o_io_lcd (lcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rs;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         have_prev = 0;
    int         prev_rise = 0;
    int         prev_wait = 0;
    int         exp_idle = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    function automatic int wait_len(input bit rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? CLRW : CMDW;
    endfunction

    // Reference model: a byte's EN rises SETUP+2 cycles after its acceptance,
    // but never before the previous byte's pulse, hold and wait have elapsed
    // plus one load cycle and the setup time.
    logic       en_prev = 1'b0;
    int         en_cnt = 0;
    int         hold_left = 0;
    bit         cur_rs;
    logic [7:0] cur_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev   = 1'b0;
            en_cnt    = 0;
            hold_left = 0;
        end else begin
            if (cyc >= 1) check("static_bits", lcd & 32'hFFFF_F900, 32'h8000_0000);
            if (lcd[10] && !en_prev) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", lcd, 32'h8000_0000);
                end else begin
                    exp_t e;
                    int   exp_rise;
                    e = q.pop_front();
                    exp_rise = e.acc + 2 + SETUP;
                    if (have_prev != 0 && prev_rise + ENC + HOLD + prev_wait + 1 + SETUP > exp_rise)
                        exp_rise = prev_rise + ENC + HOLD + prev_wait + 1 + SETUP;
                    check("rise_cycle", cyc, exp_rise);
                    check("rise_word", lcd, 32'h8000_0400 | {22'd0, e.rs, 1'b0, e.data});
                    prev_rise = exp_rise;
                    prev_wait = wait_len(e.rs, e.data);
                    have_prev = 1;
                    exp_idle  = exp_rise + ENC + HOLD + prev_wait;
                    cur_rs    = e.rs;
                    cur_data  = e.data;
                end
                en_cnt = 1;
            end else if (lcd[10] && en_prev) begin
                en_cnt++;
            end
            if (!lcd[10] && en_prev) begin
                check("en_width", en_cnt, ENC);
                hold_left = HOLD;
            end
            if (!lcd[10] && hold_left > 0) begin
                check("hold_rs_data", {lcd[9], lcd[7:0]}, {cur_rs, cur_data});
                hold_left--;
            end
            en_prev = lcd[10];
        end
    end

    task automatic push_init();
        q.delete();
        have_prev = 0;
        for (int i = 0; i < 6; i++) begin
            q.push_back('{1'b0, rom[i], (i == 0) ? PWRUP - 1 : 0});
        end
    endtask

    task automatic send(input bit rs, input logic [7:0] d, output int acc);
        int t = 0;
        @(negedge clk);
        req_if.vld  = 1'b1;
        req_if.rs   = rs;
        req_if.data = d;
        while (req_if.rdy !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            fail_now("accept");
            req_if.vld = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            q.push_back('{rs, d, acc});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop();
        req_if.vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            fail_now(name);
        end else begin
            check(name, cyc, exp_idle);
            check({name, "_queue"}, q.size(), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int t;
        req_if.vld  = 1'b0;
        req_if.rs   = 1'b0;
        req_if.data = 8'h00;

        #12;
        check("rst_lcd", lcd, 32'h0);
        check("rst_rdy", req_if.rdy, 1'b0);
        check("rst_busy", busy, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        push_init();
`ifndef LCD_FIFO_EN
        repeat (5) @(negedge clk);
        check("rdy_during_init", req_if.rdy, 1'b0);
`endif
        wait_idle("init_idle");

        send(1'b1, 8'h41, a1);
        drop();
        wait_idle("char_A_idle");

        send(1'b1, 8'h48, a1);
        send(1'b1, 8'h49, a2);
        drop();
`ifdef LCD_FIFO_EN
        check("b2b_accept", a2, a1 + 1);
`else
        check("b2b_accept", a2, a1 + 2 + SETUP + ENC + HOLD + CMDW + 1);
`endif
        wait_idle("b2b_idle");

        send(1'b0, 8'h01, a1);
        drop();
        wait_idle("clear_wait");
        send(1'b1, 8'h01, a1);
        drop();
        wait_idle("data01_wait");
        send(1'b0, 8'h02, a1);
        drop();
        wait_idle("home_wait");

        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 2));
            send(1'($urandom_range(0, 1)), d, a1);
            if ($urandom_range(0, 1) == 1) begin
                drop();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drop();
        wait_idle("random_idle");

        send(1'b1, 8'h5A, a1);
        drop();
        t = 0;
        while (lcd[10] !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) fail_now("pulse_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lcd", lcd, 32'h0);
        check("async_rst_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        push_init();
`ifdef LCD_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 8'(8'h61 + i), a1);
        end
        @(negedge clk);
        req_if.data = 8'h65;
        check("fifo_full_rdy", req_if.rdy, 1'b0);
        send(1'b1, 8'h65, a1);
        drop();
`endif
        wait_idle("replay_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
